// File: rtl/ola_trigger_pkg.sv
// Shared definitions for the trigger engine and its configuration loader:
// field-selector codes, field width formulas and the loader FSM encoding.
package ola_trigger_pkg;

  // Field selector codes carried on cfg_what / ctl_state_what
  localparam logic [1:0] WHAT_THEN_ACT  = 2'd0;
  localparam logic [1:0] WHAT_ELSE_ACT  = 2'd1;
  localparam logic [1:0] WHAT_THEN_COND = 2'd2;
  localparam logic [1:0] WHAT_ELSE_COND = 2'd3;

  // Action field: trigger strobe, state strobe, next-state index
  function automatic int unsigned action_width_f(int unsigned state_width);
    return 2 + state_width;
  endfunction

  // Condition field: value, inverted value, falling mask, rising mask
  function automatic int unsigned condition_width_f(int unsigned sample_width);
    return 4 * sample_width;
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StClear
  } loader_state_e;

endpackage

// File: rtl/ola_trigger_loader_if.sv
// Host-side command channel of the trigger loader: one field write per
// valid/ready handshake.
interface ola_trigger_loader_if #(
  parameter int unsigned state_width     = 2,
  parameter int unsigned state_ctl_width = 2,
  parameter int unsigned condition_width = 32
);

  logic                       cfg_valid;
  logic                       cfg_ready;
  logic [state_width-1:0]     cfg_which;
  logic [state_ctl_width-1:0] cfg_what;
  logic [condition_width-1:0] cfg_data;

  modport master (
    output cfg_valid,
    output cfg_which,
    output cfg_what,
    output cfg_data,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_which,
    input  cfg_what,
    input  cfg_data,
    output cfg_ready
  );

endinterface

// File: rtl/ola_trigger_shifter.sv
// Loadable MSB-first parallel-to-serial register. The low load_len bits of
// load_data are emitted one per cycle with active high; done marks the last bit.
module ola_trigger_shifter #(
  parameter int unsigned width     = 32,
  parameter int unsigned len_width = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [width-1:0]     load_data,
  input  logic [len_width-1:0] load_len,
  output logic                 active,
  output logic                 bit_out,
  output logic                 done
);

  logic [width-1:0]     aligned;
  logic [width-1:0]     shreg_q;
  logic [len_width-1:0] cnt_q;
  logic                 active_q;
  logic                 bit_q;

  // Left-align the field so its top bit sits at the register MSB
  always_comb begin
    aligned = load_data << (len_width'(width) - load_len);
  end

  // Shift state: first bit is registered at load so output starts next cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shreg_q  <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      bit_q    <= 1'b0;
    end else if (load) begin
      shreg_q  <= aligned << 1;
      bit_q    <= aligned[width-1];
      cnt_q    <= load_len - len_width'(1);
      active_q <= 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) begin
        active_q <= 1'b0;
        bit_q    <= 1'b0;
      end else begin
        bit_q   <= shreg_q[width-1];
        shreg_q <= shreg_q << 1;
        cnt_q   <= cnt_q - len_width'(1);
      end
    end
  end

  assign active  = active_q;
  assign bit_out = bit_q;
  assign done    = active_q && (cnt_q == '0);

endmodule

// File: rtl/ola_trigger_loader.sv
// Trigger configuration loader: accepts field-write commands and serialises
// them onto the trigger engine's bit-serial control port.
// Optional feature: define OLA_TRIGGER_LOADER_CLEAR_EN to add cfg_clear, which
// zero-fills every (state, field) pair.
module ola_trigger_loader
  import ola_trigger_pkg::*;
#(
  parameter int unsigned sample_width    = 8,
  parameter int unsigned state_width     = 2,
  parameter int unsigned state_count     = 4,
  parameter int unsigned state_ctl_width = 2,
  parameter int unsigned cnt_width       = 8
) (
  input  logic                       clock,
  input  logic                       reset,
`ifdef OLA_TRIGGER_LOADER_CLEAR_EN
  input  logic                       cfg_clear,
`endif
  ola_trigger_loader_if.slave        cfg,
  output logic                       busy,
  output logic                       err,
  output logic [cnt_width-1:0]       words_loaded,
  output logic                       ctl_enable,
  output logic                       ctl_data,
  output logic [state_width-1:0]     ctl_state_which,
  output logic [state_ctl_width-1:0] ctl_state_what
);

  localparam int unsigned action_width    = action_width_f(state_width);
  localparam int unsigned condition_width = condition_width_f(sample_width);
  localparam int unsigned len_width       = $clog2(condition_width + 1);

  function automatic logic [len_width-1:0] field_len(logic [state_ctl_width-1:0] what);
    return (what < WHAT_THEN_COND) ? len_width'(action_width) : len_width'(condition_width);
  endfunction

  loader_state_e               state_q, state_d;
  logic                        ready_q, ready_d;
  logic                        busy_q, busy_d;
  logic                        err_q, err_d;
  logic [cnt_width-1:0]        words_q, words_d;
  logic [state_width-1:0]      which_q, which_d;
  logic [state_ctl_width-1:0]  what_q, what_d;
`ifdef OLA_TRIGGER_LOADER_CLEAR_EN
  logic                        gap_q, gap_d;
`endif

  logic                        sh_load;
  logic [condition_width-1:0]  sh_data;
  logic [len_width-1:0]        sh_len;
  logic                        sh_done;

  ola_trigger_shifter #(
    .width     (condition_width),
    .len_width (len_width)
  ) u_shifter (
    .clock     (clock),
    .reset     (reset),
    .load      (sh_load),
    .load_data (sh_data),
    .load_len  (sh_len),
    .active    (ctl_enable),
    .bit_out   (ctl_data),
    .done      (sh_done)
  );

  // Next-state, command capture and shifter load control
  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    err_d   = err_q;
    words_d = words_q;
    which_d = which_q;
    what_d  = what_q;
`ifdef OLA_TRIGGER_LOADER_CLEAR_EN
    gap_d   = gap_q;
`endif
    sh_load = 1'b0;
    sh_data = '0;
    sh_len  = field_len(what_q);

    case (state_q)
      StIdle: begin
        ready_d = 1'b1;
`ifdef OLA_TRIGGER_LOADER_CLEAR_EN
        if (cfg_clear) begin
          state_d = StClear;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          which_d = '0;
          what_d  = state_ctl_width'(WHAT_THEN_ACT);
          gap_d   = 1'b0;
          sh_load = 1'b1;
          sh_len  = field_len(state_ctl_width'(WHAT_THEN_ACT));
        end else
`endif
        if (cfg.cfg_valid && ready_q) begin
          if (int'(cfg.cfg_which) >= state_count) begin
            // Bad index: swallow the command, flag it, engine untouched
            err_d = 1'b1;
          end else begin
            state_d = StShift;
            ready_d = 1'b0;
            busy_d  = 1'b1;
            which_d = cfg.cfg_which;
            what_d  = cfg.cfg_what;
            sh_load = 1'b1;
            sh_data = cfg.cfg_data;
            sh_len  = field_len(cfg.cfg_what);
          end
        end
      end

      StShift: begin
        if (sh_done) begin
          state_d = StIdle;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          if (words_q != {cnt_width{1'b1}}) begin
            words_d = words_q + cnt_width'(1);
          end
        end
      end

`ifdef OLA_TRIGGER_LOADER_CLEAR_EN
      StClear: begin
        if (gap_q) begin
          gap_d = 1'b0;
          if (which_q == state_width'(state_count - 1) &&
              what_q == state_ctl_width'(WHAT_ELSE_COND)) begin
            state_d = StIdle;
            ready_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            if (what_q == state_ctl_width'(WHAT_ELSE_COND)) begin
              which_d = which_q + state_width'(1);
              what_d  = state_ctl_width'(WHAT_THEN_ACT);
            end else begin
              what_d  = what_q + state_ctl_width'(1);
            end
            sh_load = 1'b1;
            sh_len  = field_len(what_d);
          end
        end else if (sh_done) begin
          // One idle cycle between fields so the engine sees a field boundary
          gap_d = 1'b1;
        end
      end
`endif

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      words_q <= '0;
      which_q <= '0;
      what_q  <= '0;
`ifdef OLA_TRIGGER_LOADER_CLEAR_EN
      gap_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      words_q <= words_d;
      which_q <= which_d;
      what_q  <= what_d;
`ifdef OLA_TRIGGER_LOADER_CLEAR_EN
      gap_q   <= gap_d;
`endif
    end
  end

  assign cfg.cfg_ready     = ready_q;
  assign busy              = busy_q;
  assign err               = err_q;
  assign words_loaded      = words_q;
  assign ctl_state_which   = which_q;
  assign ctl_state_what    = what_q;

endmodule

// File: tb/tb_ola_trigger_loader.sv
// Self-checking bench for ola_trigger_loader: table vectors, random commands
// against a field-level model, and hand sequences for the timing corners.
module tb_ola_trigger_loader;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  ola_trigger_loader_if #(.state_width(2), .state_ctl_width(2), .condition_width(32)) ifa ();
  ola_trigger_loader_if #(.state_width(2), .state_ctl_width(2), .condition_width(32)) ifb ();

  logic       busy_a, err_a, en_a, dat_a;
  logic [7:0] words_a;
  logic [1:0] which_a, what_a;
  logic       busy_b, err_b, en_b, dat_b;
  logic [7:0] words_b;
  logic [1:0] which_b, what_b;
  logic       clr_a = 1'b0;
  logic       clr_b = 1'b0;

  ola_trigger_loader dut (
    .clock           (clock),
    .reset           (reset),
`ifdef OLA_TRIGGER_LOADER_CLEAR_EN
    .cfg_clear       (clr_a),
`endif
    .cfg             (ifa.slave),
    .busy            (busy_a),
    .err             (err_a),
    .words_loaded    (words_a),
    .ctl_enable      (en_a),
    .ctl_data        (dat_a),
    .ctl_state_which (which_a),
    .ctl_state_what  (what_a)
  );

  ola_trigger_loader #(.state_count(3)) dut3 (
    .clock           (clock),
    .reset           (reset),
`ifdef OLA_TRIGGER_LOADER_CLEAR_EN
    .cfg_clear       (clr_b),
`endif
    .cfg             (ifb.slave),
    .busy            (busy_b),
    .err             (err_b),
    .words_loaded    (words_b),
    .ctl_enable      (en_b),
    .ctl_data        (dat_b),
    .ctl_state_which (which_b),
    .ctl_state_what  (what_b)
  );

  typedef struct {
    logic [1:0]  which;
    logic [1:0]  what;
    logic [31:0] data;
    int          exp_len;
    logic [31:0] exp_bits;
  } vec_t;

  vec_t vecs[5];
  int   m_words = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: action fields are 4 bits, condition fields 32 bits, low bits only
  function automatic int model_len(input logic [1:0] what);
    return (what <= 2'd1) ? 4 : 32;
  endfunction

  function automatic logic [31:0] model_bits(input logic [31:0] d, input int len);
    logic [63:0] mask;
    mask = (64'd1 << len) - 64'd1;
    return d & mask[31:0];
  endfunction

  task automatic run_cmd(input string tag, input logic [1:0] w, input logic [1:0] f,
                         input logic [31:0] d, input int exp_len, input logic [31:0] exp_bits);
    int          guard;
    int          len_obs;
    logic [31:0] bits;
    bit          stable;
    guard = 0;
    while (ifa.cfg_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    check({tag, " ready_wait"}, 64'(guard < 50), 64'd1);
    ifa.cfg_valid = 1'b1;
    ifa.cfg_which = w;
    ifa.cfg_what  = f;
    ifa.cfg_data  = d;
    tick();
    // Scramble the bus so the bench notices anything not latched
    ifa.cfg_valid = 1'b0;
    ifa.cfg_which = 2'($urandom);
    ifa.cfg_what  = 2'($urandom);
    ifa.cfg_data  = $urandom;
    len_obs = 0;
    bits    = '0;
    stable  = 1'b1;
    guard   = 0;
    while (en_a === 1'b1 && guard < 40) begin
      bits = {bits[30:0], dat_a};
      if (which_a !== w || what_a !== f || ifa.cfg_ready !== 1'b0 || busy_a !== 1'b1)
        stable = 1'b0;
      len_obs++;
      tick();
      guard++;
    end
    if (m_words < 255) m_words++;
    check({tag, " len"}, 64'(len_obs), 64'(exp_len));
    check({tag, " bits"}, 64'(bits), 64'(exp_bits));
    check({tag, " stable"}, 64'(stable), 64'd1);
    check({tag, " ready_after"}, 64'(ifa.cfg_ready), 64'd1);
    check({tag, " busy_after"}, 64'(busy_a), 64'd0);
    check({tag, " words"}, 64'(words_a), 64'(m_words));
    check({tag, " which_hold"}, 64'(which_a), 64'(w));
    check({tag, " what_hold"}, 64'(what_a), 64'(f));
  endtask

  initial begin
    logic [1:0]  rw, rf;
    logic [31:0] rd;
    logic        tr[48];
    bit          acc;
    bit          dropped;
    int          run1, gap, run2, idx, guard;

    vecs[0] = '{which: 2'd2, what: 2'd0, data: 32'h0000_000B, exp_len: 4,  exp_bits: 32'h0000_000B};
    vecs[1] = '{which: 2'd1, what: 2'd3, data: 32'hA5A5_00FF, exp_len: 32, exp_bits: 32'hA5A5_00FF};
    vecs[2] = '{which: 2'd0, what: 2'd1, data: 32'hFFFF_FFF6, exp_len: 4,  exp_bits: 32'h0000_0006};
    vecs[3] = '{which: 2'd3, what: 2'd2, data: 32'h8000_0001, exp_len: 32, exp_bits: 32'h8000_0001};
    vecs[4] = '{which: 2'd3, what: 2'd0, data: 32'h0000_0039, exp_len: 4,  exp_bits: 32'h0000_0009};

    ifa.cfg_valid = 1'b0; ifa.cfg_which = '0; ifa.cfg_what = '0; ifa.cfg_data = '0;
    ifb.cfg_valid = 1'b0; ifb.cfg_which = '0; ifb.cfg_what = '0; ifb.cfg_data = '0;

    // Reset values
    tick(); tick();
    check("rst ready", 64'(ifa.cfg_ready), 64'd0);
    check("rst busy",  64'(busy_a), 64'd0);
    check("rst err",   64'(err_a), 64'd0);
    check("rst words", 64'(words_a), 64'd0);
    check("rst en",    64'(en_a), 64'd0);
    check("rst data",  64'(dat_a), 64'd0);
    check("rst which", 64'(which_a), 64'd0);
    check("rst what",  64'(what_a), 64'd0);
    reset = 1'b1;
    #1;
    check("rel ready_pre", 64'(ifa.cfg_ready), 64'd0);
    tick();
    check("rel ready_post", 64'(ifa.cfg_ready), 64'd1);
    check("rel en", 64'(en_a), 64'd0);

    // Table vectors
    for (int i = 0; i < 5; i++) begin
      run_cmd($sformatf("vec%0d", i), vecs[i].which, vecs[i].what, vecs[i].data,
              vecs[i].exp_len, vecs[i].exp_bits);
    end

    // Random commands against the field model
    for (int i = 0; i < 30; i++) begin
      rw = 2'($urandom);
      rf = 2'($urandom);
      rd = $urandom;
      run_cmd($sformatf("rnd%0d", i), rw, rf, rd, model_len(rf), model_bits(rd, model_len(rf)));
      repeat ($urandom_range(0, 2)) tick();
    end

    // Back-to-back with valid held: exactly one idle cycle between fields
    guard = 0;
    while (ifa.cfg_ready !== 1'b1 && guard < 50) begin tick(); guard++; end
    ifa.cfg_valid = 1'b1; ifa.cfg_which = 2'd1; ifa.cfg_what = 2'd0; ifa.cfg_data = 32'h5;
    tick();
    ifa.cfg_which = 2'd2; ifa.cfg_what = 2'd2; ifa.cfg_data = 32'h1234_5678;
    for (int i = 0; i < 48; i++) begin
      tr[i] = en_a;
      acc = (ifa.cfg_ready === 1'b1) && ifa.cfg_valid;
      tick();
      if (acc) ifa.cfg_valid = 1'b0;
    end
    ifa.cfg_valid = 1'b0;
    run1 = 0; gap = 0; run2 = 0; idx = 0;
    while (idx < 48 && tr[idx] === 1'b1) begin run1++; idx++; end
    while (idx < 48 && tr[idx] === 1'b0) begin gap++; idx++; end
    while (idx < 48 && tr[idx] === 1'b1) begin run2++; idx++; end
    m_words += 2;
    check("b2b first_len", 64'(run1), 64'd4);
    check("b2b gap", 64'(gap), 64'd1);
    check("b2b second_len", 64'(run2), 64'd32);
    check("b2b words", 64'(words_a), 64'(m_words));

    // Out-of-range index on a three-state build
    check("oor err_before", 64'(err_b), 64'd0);
    ifb.cfg_valid = 1'b1; ifb.cfg_which = 2'd3; ifb.cfg_what = 2'd2; ifb.cfg_data = 32'hFFFF_FFFF;
    tick();
    ifb.cfg_valid = 1'b0;
    dropped = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (en_b !== 1'b0 || ifb.cfg_ready !== 1'b1) dropped = 1'b0;
      tick();
    end
    check("oor no_shift", 64'(dropped), 64'd1);
    check("oor err", 64'(err_b), 64'd1);
    check("oor words", 64'(words_b), 64'd0);
    ifb.cfg_valid = 1'b1; ifb.cfg_which = 2'd2; ifb.cfg_what = 2'd1; ifb.cfg_data = 32'h6;
    tick();
    ifb.cfg_valid = 1'b0;
    run1 = 0;
    for (int i = 0; i < 8; i++) begin
      if (en_b === 1'b1) run1++;
      tick();
    end
    check("oor valid_len", 64'(run1), 64'd4);
    check("oor valid_words", 64'(words_b), 64'd1);
    check("oor err_sticky", 64'(err_b), 64'd1);

    // Reset at bit 10 of a condition field
    guard = 0;
    while (ifa.cfg_ready !== 1'b1 && guard < 50) begin tick(); guard++; end
    ifa.cfg_valid = 1'b1; ifa.cfg_which = 2'd3; ifa.cfg_what = 2'd2; ifa.cfg_data = 32'hFFFF_0000;
    tick();
    ifa.cfg_valid = 1'b0;
    repeat (10) tick();
    check("mid en_before", 64'(en_a), 64'd1);
    reset = 1'b0;
    #1;
    check("mid en", 64'(en_a), 64'd0);
    check("mid data", 64'(dat_a), 64'd0);
    check("mid ready", 64'(ifa.cfg_ready), 64'd0);
    check("mid busy", 64'(busy_a), 64'd0);
    check("mid words", 64'(words_a), 64'd0);
    check("mid which", 64'(which_a), 64'd0);
    check("mid what", 64'(what_a), 64'd0);
    check("mid err_b", 64'(err_b), 64'd0);
    tick(); tick();
    reset = 1'b1;
    m_words = 0;
    run_cmd("post_rst", 2'd2, 2'd0, 32'hB, 4, 32'hB);

`ifdef OLA_TRIGGER_LOADER_CLEAR_EN
    // Zero-fill: clear wins over a simultaneous command
    guard = 0;
    while (ifa.cfg_ready !== 1'b1 && guard < 50) begin tick(); guard++; end
    clr_a = 1'b1;
    ifa.cfg_valid = 1'b1; ifa.cfg_which = 2'd1; ifa.cfg_what = 2'd0; ifa.cfg_data = 32'hF;
    tick();
    clr_a = 1'b0;
    ifa.cfg_valid = 1'b0;
    begin
      int  busy_cnt, en_cnt, fields;
      bit  ones, order_ok, prev;
      busy_cnt = 0; en_cnt = 0; fields = 0; ones = 1'b0; order_ok = 1'b1; prev = 1'b0;
      guard = 0;
      while (busy_a === 1'b1 && guard < 400) begin
        busy_cnt++;
        if (en_a === 1'b1) begin
          en_cnt++;
          if (dat_a !== 1'b0) ones = 1'b1;
          if (!prev) begin
            if (which_a !== 2'(fields / 4) || what_a !== 2'(fields % 4)) order_ok = 1'b0;
            fields++;
          end
        end
        if (ifa.cfg_ready !== 1'b0) order_ok = 1'b0;
        prev = (en_a === 1'b1);
        tick();
        guard++;
      end
      check("clr busy_cycles", 64'(busy_cnt), 64'd304);
      check("clr en_cycles", 64'(en_cnt), 64'd288);
      check("clr fields", 64'(fields), 64'd16);
      check("clr zeros", 64'(ones), 64'd0);
      check("clr order", 64'(order_ok), 64'd1);
      check("clr ready", 64'(ifa.cfg_ready), 64'd1);
      check("clr words", 64'(words_a), 64'(m_words));
      check("clr err", 64'(err_a), 64'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ola_trigger_loader.md
Name: ola_trigger_loader

Overview:
- Configuration sequencer that programs the trigger engine's per-state condition/action registers.
- Accepts one word-wide configuration command per valid/ready handshake and serialises it onto the engine's bit-serial control port (ctl_enable/ctl_data/ctl_state_which/ctl_state_what).
- Sits between the host/register interface and the trigger engine.
- While it is idle, ctl_enable is low, so the engine runs on live samples.

Parameters:
- sample_width, 8: sample bits seen by the engine.
- state_width, 2: bits of the state index.
- state_count, 4: number of engine states; must be <= 2**state_width.
- state_ctl_width, 2: width of the field selector (what).
- action_width, 1+1+state_width: bits shifted for an action field (trigger strobe, state strobe, next state).
- condition_width, 4*sample_width: bits shifted for a condition field (value, inverted value, falling, rising).
- cnt_width, 8: width of the words_loaded counter.

Ports:
- clock, in, 1: system clock; all logic is on posedge.
- reset, in, 1: asynchronous, active-low reset.
- cfg_valid, in, 1: command present.
- cfg_ready, out, 1: loader can accept a command.
- cfg_which, in, state_width: target state index.
- cfg_what, in, state_ctl_width: field selector. 0 = then-actions, 1 = else-actions, 2 = then-conditions, 3 = else-conditions.
- cfg_data, in, condition_width: field payload, right-aligned.
- busy, out, 1: a shift is in progress.
- err, out, 1: sticky; set when a command with an out-of-range state index is received.
- words_loaded, out, cnt_width: count of fields fully shifted; saturates at all-ones.
- ctl_enable, out, 1: engine control strobe.
- ctl_data, out, 1: serial payload bit.
- ctl_state_which, out, state_width: engine state select.
- ctl_state_what, out, state_ctl_width: engine field select.
- cfg_clear, in, 1: clear request; exists only with the optional feature enabled.

Behaviour:
- Reset (reset low, asynchronous):
  - FSM goes to IDLE.
  - cfg_ready=0 during reset, then 1 from the first clock edge after release.
  - busy=0, err=0, words_loaded=0, ctl_enable=0, ctl_data=0, ctl_state_which=0, ctl_state_what=0.
- FSM states: IDLE, SHIFT, CLEAR (CLEAR exists only with the feature).
- IDLE:
  - cfg_ready=1, ctl_enable=0.
  - A command is accepted on a clock edge where cfg_valid && cfg_ready.
- Command capture at acceptance:
  - Latch cfg_which into ctl_state_which and cfg_what into ctl_state_what; both stay stable until the next command.
  - Latch cfg_data into the shift register.
  - Load the bit counter: len = action_width if cfg_what<2, else condition_width.
  - Go to SHIFT.
- Out-of-range index (cfg_which >= state_count):
  - The command is consumed and dropped; err is set; the FSM stays in IDLE.
  - No ctl_enable pulse occurs and words_loaded is unchanged.
- SHIFT:
  - cfg_ready=0, busy=1, ctl_enable=1.
  - ctl_data is emitted MSB-first over the low len bits: cycle k (k=0..len-1) carries cfg_data[len-1-k]. Bits above len are ignored.
  - Exactly len consecutive cycles with ctl_enable=1, then return to IDLE.
  - words_loaded increments on the last bit, saturating.
- Latency:
  - Command accepted at edge t; ctl_enable is high for cycles t+1 .. t+len.
  - cfg_ready returns at cycle t+len+1.
  - Back-to-back commands therefore always leave at least one cycle with ctl_enable=0 between fields.
- Registered outputs: ctl_enable, ctl_data, cfg_ready and busy are all driven from registers; there is no combinational path from cfg_* to ctl_*.
- Reset mid-shift: the shift aborts immediately and ctl_enable drops. The engine field is left partially written; the host must reload it. This is not flagged.
- cfg_valid during SHIFT is ignored (ready is low). The payload must be held until accepted.

Optional Feature:
- Macro: OLA_TRIGGER_LOADER_CLEAR_EN.
- With the macro defined:
  - The cfg_clear port exists.
  - When cfg_clear=1 in IDLE, enter CLEAR. cfg_clear takes priority over cfg_valid in the same cycle; the command is not accepted.
  - CLEAR writes zeros to every (state, field) pair in order: which 0..state_count-1, and within each state what 0..3. Each pair uses its normal len with ctl_enable high, followed by one idle gap cycle.
  - Total duration = state_count*(2*action_width + 2*condition_width + 4) cycles.
  - busy=1 and cfg_ready=0 throughout CLEAR.
  - words_loaded is unaffected; err is unaffected.
- Without the macro: no cfg_clear port, no CLEAR state.

Decomposition:
- Shared package ola_trigger_pkg holds:
  - The field-selector constants WHAT_THEN_ACT=0, WHAT_ELSE_ACT=1, WHAT_THEN_COND=2, WHAT_ELSE_COND=3.
  - The action/condition width formulas, so loader and engine agree.
  - The loader FSM state encoding.
- One sub-module: ola_trigger_shifter, a loadable MSB-first parallel-to-serial register with bit counter and done pulse, reused by both SHIFT and CLEAR.

Test Plan:
1. Command which=2, what=0, data=0xB -> ctl_enable high 4 cycles; ctl_data sequence 1,0,1,1; ctl_state_which=2, ctl_state_what=0 throughout; words_loaded=1.
2. Command what=3, data=0xA5A5_00FF -> ctl_enable high 32 cycles with the MSB-first bit pattern; cfg_ready low 32 cycles, then high.
3. Two commands with cfg_valid held continuously -> exactly one ctl_enable=0 cycle between the fields; words_loaded=2.
4. Build with state_count=3: command which=3 -> no ctl_enable pulse, err=1, cfg_ready stays 1, words_loaded unchanged.
5. reset asserted at shift bit 10 of a condition field -> ctl_enable=0 immediately; all outputs at reset values; a fresh command then shifts normally.
6. With OLA_TRIGGER_LOADER_CLEAR_EN defined, pulse cfg_clear with default parameters -> 16 fields all zeros, busy high for 4*(8+64+4)=304 cycles, then cfg_ready=1.
